// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared arithmetic-family definitions: FSM state encoding and default operand width.
package serial_arith_pkg;

  localparam int   ARITH_W = 16;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/serial_subtractor_16bit_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_16bit_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, A, B, Bin, input busy, done, diff, Bout, ovf);
  modport slave  (input start, A, B, Bin, output busy, done, diff, Bout, ovf);
`else
  modport master (output start, A, B, Bin, input busy, done, diff, Bout);
  modport slave  (input start, A, B, Bin, output busy, done, diff, Bout);
`endif

endinterface

// File: rtl/serial_subtractor_16bit_full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial LSB-first subtractor: diff = A - B - Bin over WIDTH cycles.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
module serial_subtractor_16bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_16bit_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_brw;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_nxt;

  full_subtractor_1bit u_fs (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, serial shifting, and result commit on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_brw  <= 1'b0;
      r_res  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a_sh <= bus.A;
        r_b_sh <= bus.B;
        r_brw  <= bus.Bin;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_brw  <= w_bout;
        r_res  <= w_res_nxt;
        r_cnt  <= r_cnt + 1'b1;
        if (w_last) begin
          r_diff <= w_res_nxt;
          r_bout <= w_bout;
          r_done <= 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep them for the overflow test.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= bus.A[WIDTH-1];
        r_b_msb <= bus.B[WIDTH-1];
      end
      if (w_last) begin
        r_ovf <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Scoreboard bench for serial_subtractor_16bit (optionally with SERIAL_SUB_OVF_EN).
module tb_serial_subtractor_16bit;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errs;
  int   checks;
  int   done_cnt;
  int   n_push;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] hold_d;

  serial_subtractor_16bit_if #(.WIDTH(W)) bus ();

  serial_subtractor_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    logic [W:0] r;
    r     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d   = r[W-1:0];
    e.b   = r[W];
    e.o   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    e.acc = 0;
    return e;
  endfunction

  // Caller positions at a negedge; start is presented for exactly one rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bi;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) begin
      e     = model(a, b, bi);
      e.acc = cyc;
      sb.push_back(e);
      n_push++;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk_val("done_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk_val("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk_val("diff", 32'(bus.diff), 32'(mon_e.d));
        chk_val("bout", 32'(bus.Bout), 32'(mon_e.b));
        chk_val("latency", 32'(cyc - mon_e.acc), 32'(W));
`ifdef SERIAL_SUB_OVF_EN
        chk_val("ovf", 32'(bus.ovf), 32'(mon_e.o));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc       = 0;
    errs      = 0;
    checks    = 0;
    done_cnt  = 0;
    n_push    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_busy", 32'(bus.busy), 32'd0);
    chk_val("rst_done", 32'(bus.done), 32'd0);
    chk_val("rst_diff", 32'(bus.diff), 32'd0);
    chk_val("rst_bout", 32'(bus.Bout), 32'd0);
    rst_n = 1'b1;

    // Abort an operation with an asynchronous reset in mid-RUN.
    @(negedge clk);
    launch(16'h1111, 16'h0001, 1'b0, 1'b1);
    chk_val("busy_after_accept", 32'(bus.busy), 32'd1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("abort_busy", 32'(bus.busy), 32'd0);
    chk_val("abort_done", 32'(bus.done), 32'd0);
    chk_val("abort_diff", 32'(bus.diff), 32'd0);
    chk_val("abort_bout", 32'(bus.Bout), 32'd0);
    sb.delete();
    n_push = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk_val("abort_no_done", 32'(done_cnt), 32'd0);

    @(negedge clk);
    launch(16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    chk_val("done_one_cycle", 32'(bus.done), 32'd0);

    launch(16'h0003, 16'h0005, 1'b0, 1'b1);
    wait_done();
    hold_d = bus.diff;
    repeat (3) @(negedge clk);
    chk_val("diff_hold", 32'(bus.diff), 32'(hold_d));

    // Back-to-back: start held in the done cycle is accepted.
    launch(16'hCCCC, 16'h3333, 1'b1, 1'b1);
    wait_done();
    launch(16'hF0F0, 16'h0F0F, 1'b1, 1'b1);
    wait_done();

    // start and operand changes during RUN are ignored.
    @(negedge clk);
    launch(16'h1234, 16'h0234, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    launch(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    bus.A = 16'h5A5A;
    wait_done();
    repeat (25) @(negedge clk);
    chk_val("single_done", 32'(done_cnt), 32'(n_push));

`ifdef SERIAL_SUB_OVF_EN
    @(negedge clk);
    launch(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    launch(16'h0005, 16'h0003, 1'b0, 1'b1);
    wait_done();
`endif

    repeat (3) @(negedge clk);
    chk_val("sb_empty", 32'(sb.size()), 32'd0);
    chk_val("done_total", 32'(done_cnt), 32'(n_push));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
